// File: rtl/inv_round_tf_seq_if.sv
// rtl/inv_round_tf_seq_if.sv - input/result handshake bundle for the inverse round transform
interface inv_round_tf_seq_if;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] b_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] b_imc_o;
    logic [127:0] b_o;

    // block side: takes the input state, returns both result registers
    modport slave (
        input  valid_i,
        input  b_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output b_imc_o,
        output b_o
    );

    // producer/consumer side
    modport master (
        output valid_i,
        output b_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  b_imc_o,
        input  b_o
    );
endinterface

// File: rtl/inv_round_tf_seq.sv
// rtl/inv_round_tf_seq.sv - sequential InvMixColumns (one column per cycle) then InvShiftRows
module inv_round_tf_seq #(
    parameter bit EN_MC = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    inv_round_tf_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic [127:0] res_q, res_d;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    // multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // one column of InvMixColumns; 9/b/d/e multiples come from the x2/x4/x8 chain
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] p2_0, p2_1, p2_2, p2_3;
        logic [7:0] p4_0, p4_1, p4_2, p4_3;
        logic [7:0] p8_0, p8_1, p8_2, p8_3;
        logic [7:0] m9_0, m9_1, m9_2, m9_3;
        logic [7:0] mb_0, mb_1, mb_2, mb_3;
        logic [7:0] md_0, md_1, md_2, md_3;
        logic [7:0] me_0, me_1, me_2, me_3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        p2_0 = xtime(a0);   p2_1 = xtime(a1);   p2_2 = xtime(a2);   p2_3 = xtime(a3);
        p4_0 = xtime(p2_0); p4_1 = xtime(p2_1); p4_2 = xtime(p2_2); p4_3 = xtime(p2_3);
        p8_0 = xtime(p4_0); p8_1 = xtime(p4_1); p8_2 = xtime(p4_2); p8_3 = xtime(p4_3);
        m9_0 = p8_0 ^ a0;   m9_1 = p8_1 ^ a1;   m9_2 = p8_2 ^ a2;   m9_3 = p8_3 ^ a3;
        mb_0 = p8_0 ^ p2_0 ^ a0;
        mb_1 = p8_1 ^ p2_1 ^ a1;
        mb_2 = p8_2 ^ p2_2 ^ a2;
        mb_3 = p8_3 ^ p2_3 ^ a3;
        md_0 = p8_0 ^ p4_0 ^ a0;
        md_1 = p8_1 ^ p4_1 ^ a1;
        md_2 = p8_2 ^ p4_2 ^ a2;
        md_3 = p8_3 ^ p4_3 ^ a3;
        me_0 = p8_0 ^ p4_0 ^ p2_0;
        me_1 = p8_1 ^ p4_1 ^ p2_1;
        me_2 = p8_2 ^ p4_2 ^ p2_2;
        me_3 = p8_3 ^ p4_3 ^ p2_3;
        return {me_0 ^ mb_1 ^ md_2 ^ m9_3,
                m9_0 ^ me_1 ^ mb_2 ^ md_3,
                md_0 ^ m9_1 ^ me_2 ^ mb_3,
                mb_0 ^ md_1 ^ m9_2 ^ me_3};
    endfunction

    // row r of column c takes the byte from column (c - r) mod 4
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r) & 3) + r) -: 8];
            end
        end
        return o;
    endfunction

    // column currently being transformed and its InvMixColumns image
    always_comb begin
        col_in = work_q[127:96];
        unique case (col_q)
            2'd0:    col_in = work_q[127:96];
            2'd1:    col_in = work_q[95:64];
            2'd2:    col_in = work_q[63:32];
            default: col_in = work_q[31:0];
        endcase
        col_out = inv_mix_col(col_in);
    end

    // next state, working register update and result capture on entry to DONE
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    work_d = bus.b_i;
                    col_d  = 2'd0;
                    if (EN_MC) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        res_d   = inv_shift_rows(bus.b_i);
                    end
                end
            end
            BUSY: begin
                unique case (col_q)
                    2'd0:    work_d[127:96] = col_out;
                    2'd1:    work_d[95:64]  = col_out;
                    2'd2:    work_d[63:32]  = col_out;
                    default: work_d[31:0]   = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                    res_d   = inv_shift_rows(work_d);
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, column counter and data registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            res_q   <= res_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.b_imc_o = work_q;
    assign bus.b_o     = res_q;

endmodule

// File: tb/tb_inv_round_tf_seq.sv
// tb/tb_inv_round_tf_seq.sv - randomized bench for inv_round_tf_seq against a matrix-form AES model
module tb_inv_round_tf_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_round_tf_seq_if bus0 ();
    inv_round_tf_seq_if bus1 ();

    inv_round_tf_seq #(.EN_MC(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    inv_round_tf_seq #(.EN_MC(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

    logic         v_in [2];
    logic [127:0] b_in [2];
    logic         rdy  [2];
    logic         rdy_out [2];
    logic         val_out [2];
    logic [127:0] imc_out [2];
    logic [127:0] bo_out  [2];

    assign bus0.valid_i = v_in[0];
    assign bus0.b_i     = b_in[0];
    assign bus0.ready_i = rdy[0];
    assign bus1.valid_i = v_in[1];
    assign bus1.b_i     = b_in[1];
    assign bus1.ready_i = rdy[1];
    assign rdy_out[0] = bus0.ready_o;
    assign val_out[0] = bus0.valid_o;
    assign imc_out[0] = bus0.b_imc_o;
    assign bo_out[0]  = bus0.b_o;
    assign rdy_out[1] = bus1.ready_o;
    assign val_out[1] = bus1.valid_o;
    assign imc_out[1] = bus1.b_imc_o;
    assign bo_out[1]  = bus1.b_o;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // long multiplication then polynomial division by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // circulant matrix product per column; coef holds the first matrix row
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] o;
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        cf[0] = coef[31:24];
        cf[1] = coef[23:16];
        cf[2] = coef[15:8];
        cf[3] = coef[7:0];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(cf[2'((j - r) & 3)], s[127 - 8 * (4 * c + j) -: 8]);
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // dir=-1 is InvShiftRows, dir=+1 is ShiftRows
    function automatic logic [127:0] shift(input logic [127:0] s, input int dir);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + dir * r) & 3) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] fwd_round(input int m, input logic [127:0] x);
        return m != 0 ? mix(shift(x, 1), 32'h02030101) : shift(x, 1);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // one full transaction on DUT m: accept, latency, result, back-pressure, release
    task automatic xfer(input int m, input logic [127:0] din, input int hold, input bit noise,
                        output logic [127:0] g_imc, output logic [127:0] g_bo);
        int lat;
        int n;
        logic [127:0] e_imc;
        logic [127:0] e_bo;
        e_imc = m != 0 ? mix(din, 32'h0e0b0d09) : din;
        e_bo  = shift(e_imc, -1);
        @(negedge clk);
        n = 0;
        while (!rdy_out[m] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 128'(rdy_out[m]), 128'd1);
        v_in[m] = 1'b1;
        b_in[m] = din;
        rdy[m]  = noise ? 1'($urandom()) : 1'b0;
        @(negedge clk);
        lat = 1;
        v_in[m] = noise ? 1'($urandom()) : 1'b0;
        if (noise) b_in[m] = rnd128();
        while (!val_out[m] && lat < 20) begin
            if (noise) begin
                v_in[m] = 1'($urandom());
                b_in[m] = rnd128();
                rdy[m]  = 1'($urandom());
            end
            @(negedge clk);
            lat++;
        end
        rdy[m] = 1'b0;
        check("latency", 128'(lat), m != 0 ? 128'd5 : 128'd1);
        check("b_imc_o", imc_out[m], e_imc);
        check("b_o", bo_out[m], e_bo);
        g_imc = imc_out[m];
        g_bo  = bo_out[m];
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                v_in[m] = 1'($urandom());
                b_in[m] = rnd128();
            end
            @(negedge clk);
            check("hold_valid", 128'(val_out[m]), 128'd1);
            check("hold_b_o", bo_out[m], e_bo);
        end
        rdy[m] = 1'b1;
        @(negedge clk);
        rdy[m]  = 1'b0;
        v_in[m] = 1'b0;
        check("idle_ready", 128'(rdy_out[m]), 128'd1);
        check("idle_valid", 128'(val_out[m]), 128'd0);
    endtask

    logic [127:0] gi, gb, x;
    int acc0 [$];
    int acc1 [$];
    int nv;

    initial begin
        for (int m = 0; m < 2; m++) begin
            v_in[m] = 1'b0;
            b_in[m] = '0;
            rdy[m]  = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check("rst_ready", 128'(rdy_out[m]), 128'd1);
            check("rst_valid", 128'(val_out[m]), 128'd0);
            check("rst_b_o", bo_out[m], 128'd0);
            check("rst_b_imc_o", imc_out[m], 128'd0);
        end
        rst = 1'b0;

        // known-answer vectors
        xfer(1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0, 1'b0, gi, gb);
        check("kat_mc_imc", gi, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        check("kat_mc_bo", gb, 128'hdbc6015c_f213c601_010a53c6_c6012245);
        xfer(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0, 1'b0, gi, gb);
        check("kat_byp_imc", gi, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        check("kat_byp_bo", gb, 128'h8ec6019d_9f4dc601_01dca1c6_c60158bc);

        // round trip through the forward transform
        for (int m = 0; m < 2; m++) begin
            x = fwd_round(m, 128'h01234567_89abcdef_fedcba98_76543210);
            xfer(m, x, 0, 1'b0, gi, gb);
            check("round_trip", gb, 128'h01234567_89abcdef_fedcba98_76543210);
        end

        // long back-pressure with input noise
        xfer(1, rnd128(), 10, 1'b1, gi, gb);
        xfer(0, rnd128(), 10, 1'b1, gi, gb);

        // randomized states
        for (int k = 0; k < 8; k++) begin
            xfer(1, rnd128(), int'($urandom_range(0, 3)), 1'b1, gi, gb);
            xfer(0, rnd128(), int'($urandom_range(0, 3)), 1'b1, gi, gb);
        end

        // throughput with valid_i and ready_i held high
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            v_in[m] = 1'b1;
            b_in[m] = rnd128();
            rdy[m]  = 1'b1;
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (rdy_out[0]) acc0.push_back(cyc);
            if (rdy_out[1]) acc1.push_back(cyc);
            @(negedge clk);
        end
        v_in[0] = 1'b0;
        v_in[1] = 1'b0;
        repeat (8) @(negedge clk);
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        if (acc1.size() >= 2) check("thru_mc", 128'(acc1[1] - acc1[0]), 128'd6);
        else check("thru_mc_count", 128'(acc1.size()), 128'd2);
        if (acc0.size() >= 2) check("thru_byp", 128'(acc0[1] - acc0[0]), 128'd2);
        else check("thru_byp_count", 128'(acc0.size()), 128'd2);

        // reset during the second BUSY cycle
        v_in[1] = 1'b1;
        b_in[1] = rnd128();
        @(negedge clk);
        v_in[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 128'(rdy_out[1]), 128'd1);
        check("midrst_valid", 128'(val_out[1]), 128'd0);
        check("midrst_b_o", bo_out[1], 128'd0);
        check("midrst_b_imc_o", imc_out[1], 128'd0);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (val_out[1]) nv++;
        end
        check("midrst_no_valid", 128'(nv), 128'd0);
        xfer(1, rnd128(), 1, 1'b0, gi, gb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_round_tf_seq.md
# inv_round_tf_seq

Sequential inverse of the AES round transform used on the decryption side of the HEA datapath. It accepts one 128-bit state and applies InvMixColumns (one column per cycle), then InvShiftRows. It returns the result over a valid/ready handshake. With MixColumns disabled it performs InvShiftRows only, matching the final-round case of `round_tf` with `EN_MC=0`.

## Interface
- `EN_MC`, default 1: 1 = InvMixColumns then InvShiftRows; 0 = InvShiftRows only (bypass).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `valid_i`  in  1  input state valid.
- `ready_o`  out  1  block can accept an input.
- `b_i`  in  128  input state.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts the result.
- `b_imc_o`  out  128  registered InvMixColumns result, before InvShiftRows. Equals the latched `b_i` when `EN_MC=0`.
- `b_o`  out  128  registered final result, InvShiftRows(`b_imc_o`).

## Operation
- **Byte order:** byte k = `b_i[127-8k -: 8]`, k=0..15. Column c = bytes 4c..4c+3. Row r of column c = byte 4c+r.
- **InvMixColumns per column (a0..a3):**
  - a0' = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, with coefficients rotated for each row.
  - GF(2^8) multiply uses reduction polynomial 0x11B, built from xtime chains only. No multipliers, no tables.
- **InvShiftRows:** out(r,c) = in(r, (c−r) mod 4). Purely combinational from the `b_imc_o` register into the `b_o` register.
- **FSM states:** IDLE, BUSY, DONE.
  - **IDLE:** `ready_o`=1. On `valid_i`=1, latch `b_i` into the working register and clear the column counter `col` (2 bits). Go to BUSY if `EN_MC`=1, else DONE.
  - **BUSY:** `ready_o`=0. Each cycle, replace column `col` of the working register with its InvMixColumns result and increment `col`. After `col`=3 is written, go to DONE. Exactly 4 BUSY cycles. `col` wraps 3→0 without effect.
  - **DONE:** `valid_o`=1, `ready_o`=0. `b_imc_o` and `b_o` are held stable. On `ready_i`=1, go to IDLE.
- `b_o` is registered on the transition into DONE, so it is stable for the whole time `valid_o` is high.
- Inputs are ignored outside IDLE, and `b_i` may change freely while BUSY.
- `ready_i` is ignored outside DONE.

## Timing
- **Reset:** state=IDLE, `col`=0, `ready_o`=1, `valid_o`=0, `b_imc_o`=0, `b_o`=0.
- Reset asserted mid-operation (BUSY or DONE) takes effect on the next edge. The result is discarded, no `valid_o` pulse follows, and registers return to the reset values above.
- **Latency, accept edge to first `valid_o`=1 cycle:**
  - `EN_MC`=1: 5 cycles (1 accept + 4 BUSY).
  - `EN_MC`=0: 1 cycle.
- **Throughput:** one state per 6 cycles (`EN_MC`=1) or per 2 cycles (`EN_MC`=0) when `ready_i` is held at 1. The block returns to IDLE the cycle after the DONE handshake. There is no overlap.
- `valid_o` stays high indefinitely under back-pressure (`ready_i`=0), and the outputs do not change.
- `valid_i` and `ready_o` both high on the same edge is the only accept condition.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles → `ready_o`=1, `valid_o`=0, `b_o`=0, `b_imc_o`=0.
- **InvMixColumns then InvShiftRows (`EN_MC`=1):**
  - Stimulus: `b_i`=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Expected: `b_imc_o`=db135345_f20a225c_01010101_c6c6c6c6 and `b_o`=dbc6015c_f213c601_010a53c6_c6012245.
  - `valid_o` rises exactly 5 cycles after the accept edge.
- **Bypass (`EN_MC`=0), same `b_i`:** `b_o`=8ec6019d_9f4dc601_01dca1c6_c60158bc, with `valid_o` rising 1 cycle after accept.
- **Round trip:**
  - Feed `round_tf` (same `EN_MC`) output for 01234567_89abcdef_fedcba98_76543210 into this block.
  - `b_o` must equal 01234567_89abcdef_fedcba98_76543210 for both `EN_MC` values.
- **Back-pressure and ignored inputs:** hold `ready_i`=0 for 10 cycles in DONE → `valid_o` and `b_o` remain stable. Toggling `valid_i`/`b_i` during BUSY and DONE has no effect on the result.
- **Reset mid-BUSY:** accept a state, assert `rst_i` at the 2nd BUSY cycle → next cycle shows IDLE with the reset values, and no `valid_o` pulse follows. A following input completes normally with the correct result.
